ps2_key_decoder: RTL and testbench

Consumes PS/2 set-2 scan-code bytes from the keyboard receiver FIFO through its `data`/`ready`/`nextdata_n` handshake. Strips the E0/F0/E1 prefixes and emits one key event per physical make or break. Each event carries the code, the extended and break flags, and a shift-aware ASCII translation. Digital-clock control logic (time set, mode keys) consumes these events instead of raw bytes.

---
 rtl/ps2_key_decoder.sv | 163 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: turns raw receiver bytes into make/break key events with ASCII.
// Define TYPEMATIC_FILTER_EN to suppress repeated makes of the key currently held down.
module ps2_key_decoder (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] data,
    input  logic       ready,
    output logic       nextdata_n,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic [7:0] key_ascii,
    output logic       shift
);

    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    state_t     state;
    logic [7:0] byte_reg;
    logic       ext_pend;
    logic       brk_pend;
    logic [2:0] skip_cnt;
    logic       shift_l;
    logic       shift_r;
    logic       emit;
    logic       repeat_make;

    assign shift = shift_l | shift_r;

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                            input logic upper);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
            8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
            8'h3E: a = "8";  8'h46: a = "9";
            8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
            8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
            8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
            8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
            8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
            8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
            8'h35: a = "y";  8'h1A: a = "z";
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        if (upper && a >= 8'h61 && a <= 8'h7A)
            a = a - 8'h20;
        if (ext)
            a = 8'h00;
        return a;
    endfunction

    // A plain byte becomes an event unless it is a prefix, a protocol reply or part of Pause.
    always_comb begin
        emit = 1'b0;
        if (skip_cnt == 3'd0) begin
            case (byte_reg)
                8'hE0, 8'hF0, 8'hE1,
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: emit = 1'b0;
                default: emit = 1'b1;
            endcase
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    logic [7:0] held_code;
    logic       held_ext;

    assign repeat_make = emit && !brk_pend && byte_reg == held_code && ext_pend == held_ext;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            held_code <= 8'h00;
            held_ext  <= 1'b0;
        end else if (state == DECODE && emit) begin
            if (!brk_pend) begin
                held_code <= byte_reg;
                held_ext  <= ext_pend;
            end else if (byte_reg == held_code && ext_pend == held_ext) begin
                held_code <= 8'h00;
                held_ext  <= 1'b0;
            end
        end
    end
`else
    assign repeat_make = 1'b0;
`endif

    // Three-cycle byte loop: latch in IDLE, pop during POP, act on the byte in DECODE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            byte_reg   <= 8'h00;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            skip_cnt   <= 3'd0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            nextdata_n <= 1'b1;
            key_valid  <= 1'b0;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_ascii  <= 8'h00;
        end else begin
            key_valid  <= 1'b0;
            nextdata_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (ready) begin
                        byte_reg   <= data;
                        nextdata_n <= 1'b0;
                        state      <= POP;
                    end
                end
                POP: state <= DECODE;
                DECODE: begin
                    state <= IDLE;
                    if (skip_cnt != 3'd0) begin
                        // Pause sends a fixed 8-byte burst with no break; report it once at its end.
                        skip_cnt <= skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) begin
                            key_valid <= 1'b1;
                            key_code  <= 8'hE1;
                            key_ext   <= 1'b0;
                            key_break <= 1'b0;
                            key_ascii <= 8'h00;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end
                    end else if (byte_reg == 8'hE0) begin
                        ext_pend <= 1'b1;
                    end else if (byte_reg == 8'hF0) begin
                        brk_pend <= 1'b1;
                    end else if (byte_reg == 8'hE1) begin
                        skip_cnt <= 3'd7;
                    end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                        if (emit && !repeat_make) begin
                            key_valid <= 1'b1;
                            key_code  <= byte_reg;
                            key_ext   <= ext_pend;
                            key_break <= brk_pend;
                            key_ascii <= ascii_of(byte_reg, ext_pend, shift_l | shift_r);
                            if (!ext_pend && byte_reg == 8'h12)
                                shift_l <= !brk_pend;
                            if (!ext_pend && byte_reg == 8'h59)
                                shift_r <= !brk_pend;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a small receiver FIFO model feeds bytes, events are logged and checked.
module tb_ps2_key_decoder;

    logic       clk;
    logic       clr;
    logic [7:0] data;
    logic       ready;
    logic       nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [7:0] key_ascii;
    logic       shift;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    logic [7:0] ev_code  [0:31];
    logic       ev_ext   [0:31];
    logic       ev_brk   [0:31];
    logic [7:0] ev_ascii [0:31];
    logic       ev_shift [0:31];
    int ev_count = 0;
    int pop_count = 0;
    int double_pop = 0;
    logic prev_low = 1'b0;

    ps2_key_decoder dut (
        .clk(clk), .clr(clr), .data(data), .ready(ready), .nextdata_n(nextdata_n),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_break(key_break), .key_ascii(key_ascii), .shift(shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ready = (rd_ptr != wr_ptr);
    assign data  = mem[rd_ptr % 64];

    // Receiver model: the read pointer moves on the edge that ends the pop strobe.
    always @(posedge clk) begin
        if (!nextdata_n && rd_ptr != wr_ptr)
            rd_ptr <= rd_ptr + 1;
    end

    always @(negedge clk) begin
        if (!clr) begin
            if (key_valid && ev_count < 32) begin
                ev_code[ev_count]  = key_code;
                ev_ext[ev_count]   = key_ext;
                ev_brk[ev_count]   = key_break;
                ev_ascii[ev_count] = key_ascii;
                ev_shift[ev_count] = shift;
                ev_count = ev_count + 1;
            end
            if (!nextdata_n) begin
                pop_count = pop_count + 1;
                if (prev_low) double_pop = double_pop + 1;
            end
            prev_low = !nextdata_n;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_log;
        ev_count = 0;
        pop_count = 0;
        double_pop = 0;
    endtask

    task automatic wait_drain;
        int n;
        n = 0;
        while (rd_ptr != wr_ptr && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd_ptr != wr_ptr) begin
            failures++;
            $display("[TB] FAIL drain_timeout rd=%0d wr=%0d", rd_ptr, wr_ptr);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_ev(input string name, input int i, input logic [7:0] code,
                            input logic ext, input logic brk, input logic [7:0] asc);
        checks++;
        if (ev_code[i] !== code || ev_ext[i] !== ext || ev_brk[i] !== brk || ev_ascii[i] !== asc) begin
            failures++;
            $display("[TB] FAIL %s ev%0d got code=%h ext=%b brk=%b ascii=%h want code=%h ext=%b brk=%b ascii=%h",
                     name, i, ev_code[i], ev_ext[i], ev_brk[i], ev_ascii[i], code, ext, brk, asc);
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({nextdata_n, key_valid, key_code, key_ext, key_break, key_ascii, shift} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_outputs got nd=%b kv=%b code=%h ext=%b brk=%b ascii=%h sh=%b",
                     nextdata_n, key_valid, key_code, key_ext, key_break, key_ascii, shift);
        end
        clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency;
        logic [2:0] kv;
        logic [1:0] nd;
        clear_log();
        push(8'h45);
        @(negedge clk); kv[0] = key_valid; nd[0] = nextdata_n;
        @(negedge clk); kv[1] = key_valid; nd[1] = nextdata_n;
        @(negedge clk); kv[2] = key_valid;
        checks++;
        if (kv !== 3'b100 || nd !== 2'b10) begin
            failures++;
            $display("[TB] FAIL latency got kv=%b nd=%b want kv=100 nd=10", kv, nd);
        end
        checks++;
        if (key_ascii !== 8'h30) begin
            failures++;
            $display("[TB] FAIL latency_ascii got=%h want=30", key_ascii);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_make_break;
        clear_log();
        push(8'h1C); push(8'hF0); push(8'h1C);
        wait_drain();
        check_count("mb_events", ev_count, 2);
        check_ev("mb", 0, 8'h1C, 1'b0, 1'b0, 8'h61);
        check_ev("mb", 1, 8'h1C, 1'b0, 1'b1, 8'h61);
        check_count("mb_pops", pop_count, 3);
        check_count("mb_double_pop", double_pop, 0);
    endtask

    task automatic test_shift;
        clear_log();
        push(8'h12); push(8'h1C); push(8'hF0); push(8'h12); push(8'h1C);
        wait_drain();
        check_count("shift_events", ev_count, 4);
        check_ev("shift", 0, 8'h12, 1'b0, 1'b0, 8'h00);
        check_ev("shift", 1, 8'h1C, 1'b0, 1'b0, 8'h41);
        check_ev("shift", 2, 8'h12, 1'b0, 1'b1, 8'h00);
        check_ev("shift", 3, 8'h1C, 1'b0, 1'b0, 8'h61);
        checks++;
        if ({ev_shift[0], ev_shift[2], shift} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL shift_flag got=%b%b%b want=100", ev_shift[0], ev_shift[2], shift);
        end
        // Right shift uses the other flag.
        clear_log();
        push(8'h59); push(8'h4D); push(8'hF0); push(8'h59);
        wait_drain();
        check_ev("rshift", 1, 8'h4D, 1'b0, 1'b0, 8'h50);
        check_count("rshift_released", {31'd0, shift}, 0);
    endtask

    task automatic test_extended;
        clear_log();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        wait_drain();
        check_count("ext_events", ev_count, 2);
        check_ev("ext", 0, 8'h75, 1'b1, 1'b0, 8'h00);
        check_ev("ext", 1, 8'h75, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic test_misc_ascii;
        clear_log();
        push(8'h29); push(8'h5A); push(8'h66); push(8'h46); push(8'hE0); push(8'h1C);
        wait_drain();
        check_count("misc_events", ev_count, 5);
        check_ev("misc", 0, 8'h29, 1'b0, 1'b0, 8'h20);
        check_ev("misc", 1, 8'h5A, 1'b0, 1'b0, 8'h0D);
        check_ev("misc", 2, 8'h66, 1'b0, 1'b0, 8'h08);
        check_ev("misc", 3, 8'h46, 1'b0, 1'b0, 8'h39);
        check_ev("misc", 4, 8'h1C, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_pause;
        logic [7:0] seq [0:9];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA, 8'hFA};
        clear_log();
        for (int i = 0; i < 10; i++) push(seq[i]);
        wait_drain();
        check_count("pause_events", ev_count, 1);
        check_ev("pause", 0, 8'hE1, 1'b0, 1'b0, 8'h00);
        check_count("pause_pops", pop_count, 10);
    endtask

    task automatic test_typematic;
        clear_log();
        push(8'h16); push(8'h16); push(8'h16); push(8'hF0); push(8'h16);
        wait_drain();
`ifdef TYPEMATIC_FILTER_EN
        check_count("typematic_events", ev_count, 2);
        check_ev("typematic", 0, 8'h16, 1'b0, 1'b0, 8'h31);
        check_ev("typematic", 1, 8'h16, 1'b0, 1'b1, 8'h31);
`else
        check_count("typematic_events", ev_count, 4);
        check_ev("typematic", 0, 8'h16, 1'b0, 1'b0, 8'h31);
        check_ev("typematic", 2, 8'h16, 1'b0, 1'b0, 8'h31);
        check_ev("typematic", 3, 8'h16, 1'b0, 1'b1, 8'h31);
`endif
    endtask

    task automatic test_clr_mid;
        clear_log();
        push(8'hE0);
        wait_drain();
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (nextdata_n !== 1'b1 || key_valid !== 1'b0 || key_code !== 8'h00) begin
            failures++;
            $display("[TB] FAIL clr_pulse got nd=%b kv=%b code=%h want nd=1 kv=0 code=00",
                     nextdata_n, key_valid, key_code);
        end
        clr = 1'b0;
        @(negedge clk);
        clear_log();
        push(8'h1C);
        wait_drain();
        check_count("clr_events", ev_count, 1);
        check_ev("clr", 0, 8'h1C, 1'b0, 1'b0, 8'h61);
    endtask

    initial begin
        clr = 1'b1;
        test_reset();
        test_latency();
        test_make_break();
        test_shift();
        test_extended();
        test_misc_ascii();
        test_pause();
        test_typematic();
        test_clr_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
